hazard_stall_ctrl: RTL

// Decode-side hazard controller for the 5-stage MIPS pipeline with jal/jr. It detects

---
 rtl/hazard_stall_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Decode-side hazard controller: load-use and jr-in-ID stalls, jump flush, jr MEM bypass
// select, stall watchdog and saturating stall/jump counters.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_freeze,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_is_jr,
  input  logic             ID_jump,
  input  logic [4:0]       EXE_dst,
  input  logic             EXE_RegWrite,
  input  logic             EXE_MemRead,
  input  logic [4:0]       MEM_dst,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             jr_fwd_mem,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] jump_count
);

  localparam int unsigned ConsecW = $clog2(MAX_STALL + 1);

  typedef enum logic [0:0] {StRun, StStall} stateE;

  stateE              stateQ;
  logic [ConsecW-1:0] consecQ;

  logic exeMatchRs, exeMatchRt, memMatchRs;
  logic loadUse, jrEx, jrMl, hazard, takenJump;

  // $0 is hard-wired, so a zero destination never creates a dependency.
  always_comb begin
    exeMatchRs = (EXE_dst != 5'd0) && (EXE_dst == ID_rs);
    exeMatchRt = (EXE_dst != 5'd0) && (EXE_dst == ID_rt);
    memMatchRs = (MEM_dst != 5'd0) && (MEM_dst == ID_rs);
    loadUse    = EXE_MemRead && ((exeMatchRs && ID_uses_rs) || (exeMatchRt && ID_uses_rt));
    jrEx       = ID_is_jr && EXE_RegWrite && exeMatchRs;
    jrMl       = ID_is_jr && MEM_MemRead && memMatchRs;
    hazard     = loadUse || jrEx || jrMl;
    jr_fwd_mem = ID_is_jr && MEM_RegWrite && !MEM_MemRead && memMatchRs;
    takenJump  = ID_jump && !hazard;
  end

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    if (reset) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end else if (ext_freeze) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
    end else if (hazard) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end else if (ID_jump) begin
      IF_ID_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ       <= StRun;
      consecQ      <= '0;
      stall_err    <= 1'b0;
      stall_cycles <= '0;
      jump_count   <= '0;
    end else if (!ext_freeze) begin
      case (stateQ)
        StRun:   if (hazard)  stateQ <= StStall;
        StStall: if (!hazard) stateQ <= StRun;
        default: stateQ <= StRun;
      endcase
      if (hazard) begin
        if (consecQ != ConsecW'(MAX_STALL)) consecQ <= consecQ + ConsecW'(1);
        if (32'(consecQ) + 32'd1 >= MAX_STALL) stall_err <= 1'b1;
        if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      end else begin
        consecQ <= '0;
      end
      if (takenJump && (jump_count != '1)) jump_count <= jump_count + CNT_W'(1);
    end
  end

endmodule
